// File: rtl/roulette_n.sv
// roulette_n: one-hot ring position generator that spins at a programmable
// step period, then decelerates by stretching the period on every step
// before halting with a single-cycle done pulse.
// Optional feature: define ROULETTE_BOUNCE_EN to add the i_bounce input,
// which makes the position reflect at the ring ends instead of wrapping.
//
// state   | meaning
// S_IDLE  | halted, position held, waiting for start
// S_SPIN  | stepping at the period captured at start
// S_DECEL | stepping with the period roughly doubled after every step
module roulette_n #(
  parameter  int N           = 6,
  parameter  int DIV_W       = 24,
  parameter  int DECEL_STEPS = 4,
  localparam int IW          = $clog2(N)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_dir,
`ifdef ROULETTE_BOUNCE_EN
  input  logic             i_bounce,
`endif
  input  logic [DIV_W-1:0] i_period,
  output logic [N-1:0]     o_pos,
  output logic [IW-1:0]    o_idx,
  output logic             o_busy,
  output logic             o_step,
  output logic             o_done
);

  typedef enum logic [1:0] {S_IDLE, S_SPIN, S_DECEL} state_t;

  state_t           r_state, w_state_nxt;
  logic [DIV_W-1:0] r_cnt, w_cnt_nxt;
  logic [DIV_W-1:0] r_cur_period, w_cur_nxt;
  logic [3:0]       r_dcnt, w_dcnt_nxt;
  logic [IW-1:0]    r_idx, w_idx_nxt, w_idx_step;
  logic [N-1:0]     r_pos;
  logic             r_step, w_step_nxt;
  logic             r_done, w_done_nxt;
  logic             w_move;
  logic             w_tick;
  logic [3:0]       w_dcnt_inc;
  logic [DIV_W-1:0] w_cur_slow;
  logic             w_at_top, w_at_bot;
`ifdef ROULETTE_BOUNCE_EN
  logic             r_dir, w_dir_nxt, w_dir_step;
`endif

  assign w_tick     = (r_cnt == r_cur_period);
  assign w_dcnt_inc = r_dcnt + 4'd1;
  // Once the top bit is set a further shift would lose it, so clamp to all-ones.
  assign w_cur_slow = r_cur_period[DIV_W-1] ? '1 : {r_cur_period[DIV_W-2:0], 1'b1};
  assign w_at_top   = (r_idx == IW'(N-1));
  assign w_at_bot   = (r_idx == '0);

  // Target index (and reflected direction) for the next step.
  always_comb begin
    w_idx_step = r_idx;
`ifdef ROULETTE_BOUNCE_EN
    w_dir_step = r_dir;
    if (i_bounce) begin
      if (!r_dir) begin
        if (w_at_top) begin
          w_dir_step = 1'b1;
          w_idx_step = r_idx - IW'(1);
        end else begin
          w_idx_step = r_idx + IW'(1);
        end
      end else begin
        if (w_at_bot) begin
          w_dir_step = 1'b0;
          w_idx_step = r_idx + IW'(1);
        end else begin
          w_idx_step = r_idx - IW'(1);
        end
      end
    end else
`endif
    begin
      if (!i_dir) w_idx_step = w_at_top ? '0 : r_idx + IW'(1);
      else        w_idx_step = w_at_bot ? IW'(N-1) : r_idx - IW'(1);
    end
  end

  // Next-state and datapath decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cur_nxt   = r_cur_period;
    w_dcnt_nxt  = r_dcnt;
    w_idx_nxt   = r_idx;
    w_step_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    w_move      = 1'b0;
`ifdef ROULETTE_BOUNCE_EN
    w_dir_nxt   = r_dir;
`endif
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = S_SPIN;
          w_cur_nxt   = i_period;
          w_cnt_nxt   = '0;
`ifdef ROULETTE_BOUNCE_EN
          w_dir_nxt   = i_dir;
`endif
        end
      end
      S_SPIN: begin
        if (w_tick) begin
          w_cnt_nxt = '0;
          w_move    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + DIV_W'(1);
        end
        // A step on this same cycle still belongs to SPIN.
        if (i_stop) begin
          w_state_nxt = S_DECEL;
          w_dcnt_nxt  = '0;
        end
      end
      S_DECEL: begin
        if (w_tick) begin
          w_cnt_nxt  = '0;
          w_move     = 1'b1;
          w_dcnt_nxt = w_dcnt_inc;
          w_cur_nxt  = w_cur_slow;
          if (w_dcnt_inc == 4'(DECEL_STEPS)) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + DIV_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_move) begin
      w_step_nxt = 1'b1;
      w_idx_nxt  = w_idx_step;
`ifdef ROULETTE_BOUNCE_EN
      w_dir_nxt  = w_dir_step;
`endif
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_cur_period <= '0;
      r_dcnt       <= '0;
      r_idx        <= '0;
      r_pos        <= N'(1);
      r_step       <= 1'b0;
      r_done       <= 1'b0;
`ifdef ROULETTE_BOUNCE_EN
      r_dir        <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_cur_period <= w_cur_nxt;
      r_dcnt       <= w_dcnt_nxt;
      r_idx        <= w_idx_nxt;
      r_pos        <= N'(1) << w_idx_nxt;
      r_step       <= w_step_nxt;
      r_done       <= w_done_nxt;
`ifdef ROULETTE_BOUNCE_EN
      r_dir        <= w_dir_nxt;
`endif
    end
  end

  assign o_pos  = r_pos;
  assign o_idx  = r_idx;
  assign o_busy = (r_state != S_IDLE);
  assign o_step = r_step;
  assign o_done = r_done;

endmodule

// File: tb/tb_roulette_n.sv
// Testbench for roulette_n: directed scenarios followed by random stimulus,
// with every output compared each cycle against an interval-based model.
module tb_roulette_n;
  localparam int N           = 6;
  localparam int DIV_W       = 24;
  localparam int DECEL_STEPS = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, start, stop, dir;
  logic [DIV_W-1:0] period;
`ifdef ROULETTE_BOUNCE_EN
  logic             bounce;
`endif
  logic [N-1:0]     pos;
  logic [2:0]       idx;
  logic             busy, step, done;

  int n_assert = 0;
  int n_fail   = 0;

  roulette_n #(.N(N), .DIV_W(DIV_W), .DECEL_STEPS(DECEL_STEPS)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_start  (start),
    .i_stop   (stop),
    .i_dir    (dir),
`ifdef ROULETTE_BOUNCE_EN
    .i_bounce (bounce),
`endif
    .i_period (period),
    .o_pos    (pos),
    .o_idx    (idx),
    .o_busy   (busy),
    .o_step   (step),
    .o_done   (done)
  );

  // Reference model: position index, cycles left until the next step,
  // current step interval and number of deceleration steps taken.
  int     m_idx, m_wait, m_dsteps;
  longint m_per;
  bit     m_active, m_decel, m_step, m_done, m_bdir;

  function automatic void model_move();
    bit b;
    int d, nxt;
    b = 1'b0;
`ifdef ROULETTE_BOUNCE_EN
    b = bounce;
`endif
    if (b) d = int'(m_bdir);
    else   d = int'(dir);
    nxt = m_idx + (d != 0 ? -1 : 1);
    if (nxt < 0 || nxt >= N) begin
      if (b) begin
        m_bdir = !m_bdir;
        nxt = m_idx + (m_bdir ? -1 : 1);
      end else begin
        nxt = (nxt + N) % N;
      end
    end
    m_idx = nxt;
  endfunction

  function automatic void model_edge();
    bit was_decel;
    m_step = 1'b0;
    m_done = 1'b0;
    if (rst) begin
      m_idx = 0; m_active = 0; m_decel = 0; m_bdir = 0;
      m_wait = 0; m_dsteps = 0; m_per = 0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1; m_decel = 0;
        m_per = longint'(period);
        m_wait = int'(m_per) + 1;
        m_bdir = dir;
      end
    end else begin
      was_decel = m_decel;
      m_wait--;
      if (!m_decel && stop) begin
        m_decel = 1; m_dsteps = 0;
      end
      if (m_wait == 0) begin
        model_move();
        m_step = 1;
        if (was_decel) begin
          m_dsteps++;
          if (m_per >= (longint'(1) << (DIV_W-1))) m_per = (longint'(1) << DIV_W) - 1;
          else                                     m_per = 2*m_per + 1;
          if (m_dsteps == DECEL_STEPS) begin
            m_active = 0; m_done = 1;
          end
        end
        m_wait = int'(m_per) + 1;
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
    chk("m_pos",  64'(pos),  64'(1) << m_idx);
    chk("m_idx",  64'(idx),  64'(m_idx));
    chk("m_busy", 64'(busy), 64'(m_active));
    chk("m_step", 64'(step), 64'(m_step));
    chk("m_done", 64'(done), 64'(m_done));
  endtask

  task automatic wait_step(input int maxc, output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!step && n < maxc);
    chk("step_timeout", 64'(step), 64'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (busy && n < 300) begin
      cyc();
      n++;
    end
    chk("drain_timeout", 64'(busy), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k;
    int exp31[6];
    int exp33[4];
    exp31 = '{2, 4, 8, 16, 32, 1};
    exp33 = '{3, 8, 16, 32};
    rst = 1; start = 0; stop = 0; dir = 0; period = '0;
`ifdef ROULETTE_BOUNCE_EN
    bounce = 0;
`endif
    #1;
    cyc(); cyc();
    chk("rst_pos",  64'(pos),  64'd1);
    chk("rst_idx",  64'(idx),  64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst = 0;
    cyc();

    // Spin at period 3 through one full revolution.
    period = 3; start = 1; cyc(); start = 0;
    chk("spin_busy", 64'(busy), 64'd1);
    k = 0;
    for (int i = 0; i < 26; i++) begin
      cyc();
      if (step && k < 6) begin
        chk("spin_seq", 64'(pos), 64'(exp31[k]));
        k++;
      end
    end
    chk("spin_steps", 64'(k), 64'd6);

    // Stop one cycle after a step: deceleration intervals.
    wait_step(20, n);
    stop = 1; cyc(); stop = 0;
    for (int s = 0; s < 4; s++) begin
      wait_step(100, n);
      chk("decel_int", 64'(n), 64'(exp33[s]));
    end
    chk("decel_done", 64'(done), 64'd1);
    cyc();
    chk("idle_busy", 64'(busy), 64'd0);
    repeat (5) cyc();
    chk("pos_hold", 64'(pos), 64'd32);

    // Reverse direction from reset.
    rst = 1; cyc(); rst = 0;
    dir = 1; period = 3; start = 1; cyc(); start = 0;
    wait_step(20, n);
    chk("rev_idx1", 64'(idx), 64'd5);
    chk("rev_pos1", 64'(pos), 64'd32);
    wait_step(20, n);
    chk("rev_idx2", 64'(idx), 64'd4);

    // Reset in the middle of deceleration.
    stop = 1; cyc(); stop = 0;
    repeat (10) cyc();
    rst = 1; cyc(); rst = 0;
    chk("abort_pos",  64'(pos),  64'd1);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    for (int i = 0; i < 40; i++) begin
      cyc();
      chk("abort_nodone", 64'(done), 64'd0);
    end
    period = 1; dir = 0; start = 1; cyc(); start = 0;
    wait_step(20, n);
    chk("restart_int", 64'(n), 64'd2);
    chk("restart_idx", 64'(idx), 64'd1);
    stop = 1; cyc(); stop = 0;
    drain();

    // start and stop together in IDLE with period 0.
    period = 0; start = 1; stop = 1; cyc(); start = 0; stop = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("p0_step", 64'(step), 64'd1);
      chk("p0_busy", 64'(busy), 64'd1);
    end
    stop = 1; cyc(); stop = 0;
    drain();

`ifdef ROULETTE_BOUNCE_EN
    begin
      int expb[11];
      expb = '{1, 2, 3, 4, 5, 4, 3, 2, 1, 0, 1};
      rst = 1; cyc(); rst = 0;
      bounce = 1; dir = 0; period = 0; start = 1; cyc(); start = 0;
      for (int i = 0; i < 11; i++) begin
        cyc();
        chk("bounce_idx", 64'(idx), 64'(expb[i]));
      end
      stop = 1; cyc(); stop = 0;
      drain();
    end
`endif

    // Random stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      rst    = ($urandom_range(0, 199) == 0);
      start  = ($urandom_range(0, 7) == 0);
      stop   = ($urandom_range(0, 15) == 0);
      dir    = 1'($urandom_range(0, 1));
      period = DIV_W'($urandom_range(0, 5));
`ifdef ROULETTE_BOUNCE_EN
      bounce = 1'($urandom_range(0, 1));
`endif
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
